alu_8bit: RTL and testbench



---
 rtl/alu_8bit.sv | 102 ++++++++++
 tb/tb_alu_8bit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU (add/sub/logic/shift/set-less-than) with ZF/SF/OF/CF; optional rotates under ALU_ROTATE_EN.
// Latency 1 cycle; accepts a new operation every clock.
// No backpressure: no enable, every rising edge loads a new result.
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] aluop,
    output logic [7:0] alu_res,
    output logic       ZF,
    output logic       SF,
    output logic       OF,
    output logic       CF
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_SAR  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
`ifdef ALU_ROTATE_EN
    localparam logic [3:0] OP_ROL  = 4'b1011;
    localparam logic [3:0] OP_ROR  = 4'b1100;
`endif

    logic       is_sub;
    logic [7:0] b_op;
    logic [8:0] sum;
    logic [2:0] sh;
    logic [7:0] res_nxt;
    logic       of_nxt;
    logic       cf_nxt;

    // Single shared adder: SUB is A + ~B + 1
    assign is_sub = (aluop == OP_SUB);
    assign b_op   = is_sub ? ~B : B;
    assign sum    = {1'b0, A} + {1'b0, b_op} + {8'b0, is_sub};
    assign sh     = B[2:0];

`ifdef ALU_ROTATE_EN
    logic [15:0] rol_ext;
    logic [15:0] ror_ext;
    assign rol_ext = {A, A} << sh;
    assign ror_ext = {A, A} >> sh;
`endif

    always_comb begin
        res_nxt = 8'h00;
        of_nxt  = 1'b0;
        cf_nxt  = 1'b0;
        case (aluop)
            OP_ADD: begin
                res_nxt = sum[7:0];
                cf_nxt  = sum[8];
                of_nxt  = (A[7] == B[7]) && (sum[7] != A[7]);
            end
            OP_SUB: begin
                res_nxt = sum[7:0];
                cf_nxt  = ~sum[8];
                of_nxt  = (A[7] != B[7]) && (sum[7] != A[7]);
            end
            OP_AND:  res_nxt = A & B;
            OP_OR:   res_nxt = A | B;
            OP_NOT:  res_nxt = ~A;
            OP_XOR:  res_nxt = A ^ B;
            OP_SHL:  res_nxt = A << sh;
            OP_SHR:  res_nxt = A >> sh;
            OP_SAR:  res_nxt = $unsigned($signed(A) >>> sh);
            OP_SLT:  res_nxt = {7'b0, ($signed(A) < $signed(B))};
            OP_SLTU: res_nxt = {7'b0, (A < B)};
`ifdef ALU_ROTATE_EN
            OP_ROL:  res_nxt = rol_ext[15:8];
            OP_ROR:  res_nxt = ror_ext[7:0];
`endif
            default: res_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_res <= 8'h00;
            ZF      <= 1'b0;
            SF      <= 1'b0;
            OF      <= 1'b0;
            CF      <= 1'b0;
        end else begin
            alu_res <= res_nxt;
            ZF      <= (res_nxt == 8'h00);
            SF      <= res_nxt[7];
            OF      <= of_nxt;
            CF      <= cf_nxt;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: expected {res,ZF,SF,OF,CF} queued at drive time, popped one cycle later.
module tb_alu_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] aluop;
    logic [7:0] alu_res;
    logic       ZF, SF, OF, CF;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    alu_8bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .aluop   (aluop),
        .alu_res (alu_res),
        .ZF      (ZF),
        .SF      (SF),
        .OF      (OF),
        .CF      (CF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got res=%02h zsoc=%04b expected res=%02h zsoc=%04b",
                     tag, got[11:4], got[3:0], exp[11:4], exp[3:0]);
        end
    endtask

    // Independent reference using integer arithmetic
    function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r, s, amt;
        logic o, c;
        logic [7:0] res;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); amt = b[2:0];
        r = 0; o = 1'b0; c = 1'b0;
        case (op)
            4'd0: begin r = ua + ub; c = (r > 255); s = sa + sb; o = (s > 127) || (s < -128); end
            4'd1: begin r = ua - ub; c = (ua < ub); s = sa - sb; o = (s > 127) || (s < -128); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = 255 - ua;
            4'd5: r = ua ^ ub;
            4'd6: r = ua << amt;
            4'd7: r = ua >> amt;
            4'd8: r = sa >>> amt;
            4'd9: r = (sa < sb) ? 1 : 0;
            4'd10: r = (ua < ub) ? 1 : 0;
`ifdef ALU_ROTATE_EN
            4'd11: r = (ua << amt) | (ua >> (8 - amt));
            4'd12: r = (ua >> amt) | (ua << (8 - amt));
`endif
            default: r = 0;
        endcase
        res = r[7:0];
        return {res, (res == 8'h00), res[7], o, c};
    endfunction

    task automatic drive(input string tag, input logic rst, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic [11:0] exp);
        rst_n = rst;
        aluop = op;
        A     = a;
        B     = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Output monitor: compare one cycle after each edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), {alu_res, ZF, SF, OF, CF}, exp_q.pop_front());
        end
    end

    initial begin
        logic [3:0] rop;
        logic [7:0] ra, rb;

        // Reset state, then first edge out of reset
        drive("reset_init", 1'b0, 4'd0, 8'h78, 8'h08, 12'h000);
        drive("reset_rel",  1'b1, 4'd0, 8'h78, 8'h08, {8'h80, 4'b0110});

        drive("add_7f",  1'b1, 4'd0, 8'h78, 8'h07, {8'h7F, 4'b0000});
        drive("add_ovf", 1'b1, 4'd0, 8'h78, 8'h08, {8'h80, 4'b0110});
        drive("add_cy",  1'b1, 4'd0, 8'h88, 8'hF8, {8'h80, 4'b0101});
        drive("add_cyo", 1'b1, 4'd0, 8'h88, 8'hF7, {8'h7F, 4'b0011});
        drive("add_z",   1'b1, 4'd0, 8'hFA, 8'h06, {8'h00, 4'b1001});

        drive("sub_80",  1'b1, 4'd1, 8'h88, 8'h08, {8'h80, 4'b0100});
        drive("sub_ovf", 1'b1, 4'd1, 8'h88, 8'h09, {8'h7F, 4'b0010});
        drive("sub_01",  1'b1, 4'd1, 8'hFA, 8'hF9, {8'h01, 4'b0000});
        drive("sub_bor", 1'b1, 4'd1, 8'hFA, 8'hFB, {8'hFF, 4'b0101});
        drive("sub_z",   1'b1, 4'd1, 8'h88, 8'h88, {8'h00, 4'b1000});

        drive("and",  1'b1, 4'd2, 8'h78, 8'h07, {8'h00, 4'b1000});
        drive("or",   1'b1, 4'd3, 8'h78, 8'h08, {8'h78, 4'b0000});
        drive("not",  1'b1, 4'd4, 8'h88, 8'h5A, {8'h77, 4'b0000});
        drive("xor",  1'b1, 4'd5, 8'h88, 8'hF7, {8'h7F, 4'b0000});
        drive("shl",  1'b1, 4'd6, 8'h78, 8'h03, {8'hC0, 4'b0100});
        drive("shr",  1'b1, 4'd7, 8'h78, 8'h03, {8'h0F, 4'b0000});
        drive("sar",  1'b1, 4'd8, 8'h88, 8'h03, {8'hF1, 4'b0100});

        drive("slt0",  1'b1, 4'd9,  8'h78, 8'h08, {8'h00, 4'b1000});
        drive("slt1",  1'b1, 4'd9,  8'h88, 8'hF8, {8'h01, 4'b0000});
        drive("sltu0", 1'b1, 4'd10, 8'hFA, 8'hF9, {8'h00, 4'b1000});
        drive("sltu1", 1'b1, 4'd10, 8'hFA, 8'hFB, {8'h01, 4'b0000});

`ifdef ALU_ROTATE_EN
        drive("rol", 1'b1, 4'd11, 8'h81, 8'h01, {8'h03, 4'b0000});
        drive("ror", 1'b1, 4'd12, 8'h81, 8'h01, {8'hC0, 4'b0100});
`else
        drive("rol_undef", 1'b1, 4'd11, 8'h81, 8'h01, {8'h00, 4'b1000});
        drive("ror_undef", 1'b1, 4'd12, 8'h81, 8'h01, {8'h00, 4'b1000});
`endif
        drive("op_f", 1'b1, 4'd15, 8'hFF, 8'hFF, {8'h00, 4'b1000});

        // Reset mid-stream discards the in-flight op
        drive("pre_rst", 1'b1, 4'd0, 8'h88, 8'hF7, {8'h7F, 4'b0011});
        drive("mid_rst", 1'b0, 4'd0, 8'h78, 8'h08, 12'h000);
        drive("post_rst", 1'b1, 4'd1, 8'hFA, 8'hFB, {8'hFF, 4'b0101});

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            drive("rand", 1'b1, rop, ra, rb, model(rop, ra, rb));
        end

        @(posedge clk);
        #3;
        check("drain", {8'(exp_q.size()), 4'b0}, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
